// File: rtl/mem_access_unit.sv
// RV32I memory-access stage: loads/stores over a req/ack data bus,
// stalling upstream until the access completes, times out or faults.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic [1:0]  excp_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t state, nstate;

  logic [15:0] cnt;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic        ld_q;
  logic [31:0] res_q;
  logic        err_q;

  logic        access;
  logic        illegal;
  logic        misalign;
  logic        go;
  logic        timeout;
  logic [3:0]  be_d;
  logic [31:0] sdata_d;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_fmt;

  logic        stall;
  logic        wreg;
  logic [31:0] wdata;
  logic [1:0]  excp;

  assign access  = mem_rd_i | mem_wr_i;
  assign go      = access & ~illegal & ~misalign;
  assign timeout = (cnt == LAST);

  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      mem_rd_i && mem_wr_i:
        illegal = 1'b1;
      mem_rd_i && !mem_wr_i:
        illegal = !(mem_op_i inside
          {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      mem_wr_i && !mem_rd_i:
        illegal = !(mem_op_i inside
          {3'b000, 3'b001, 3'b010});
      default:
        illegal = 1'b0;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    if (access) begin
      unique case (mem_op_i[1:0])
        2'b01:   misalign = mem_addr_i[0];
        2'b10:   misalign = |mem_addr_i[1:0];
        default: misalign = 1'b0;
      endcase
    end
  end

  always_comb begin
    be_d    = 4'b0000;
    sdata_d = '0;
    if (mem_wr_i) begin
      unique case (mem_op_i[1:0])
        2'b00: begin
          be_d    = 4'b0001 << mem_addr_i[1:0];
          sdata_d = {4{mem_sdata_i[7:0]}};
        end
        2'b01: begin
          be_d    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
          sdata_d = {2{mem_sdata_i[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          sdata_d = mem_sdata_i;
        end
      endcase
    end
  end

  // Load lane selection uses the byte offset latched at issue.
  always_comb begin
    lb = dmem_rdata_i[{off_q, 3'b000} +: 8];
    lh = off_q[1] ? dmem_rdata_i[31:16]
                  : dmem_rdata_i[15:0];
    unique case (op_q)
      3'b000:  ld_fmt = {{24{lb[7]}}, lb};
      3'b100:  ld_fmt = {24'b0, lb};
      3'b001:  ld_fmt = {{16{lh[15]}}, lh};
      3'b101:  ld_fmt = {16'b0, lh};
      default: ld_fmt = dmem_rdata_i;
    endcase
  end

  always_comb begin
    nstate = state;
    stall  = 1'b0;
    wreg   = 1'b0;
    wdata  = wdata_i;
    excp   = 2'b00;
    unique case (state)
      IDLE: begin
        if (!access) begin
          wreg = wreg_i;
        end else if (illegal) begin
          excp = 2'b11;
        end else if (misalign) begin
          excp = 2'b01;
        end else begin
          stall  = 1'b1;
          nstate = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_ack_i || timeout) nstate = DONE;
      end
      DONE: begin
        nstate = IDLE;
        wdata  = res_q;
        if (err_q)     excp = 2'b10;
        else if (ld_q) wreg = wreg_i;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      off_q   <= '0;
      ld_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nstate;
      unique case (state)
        IDLE: begin
          if (go) begin
            req_q   <= 1'b1;
            we_q    <= mem_wr_i;
            addr_q  <= {mem_addr_i[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= sdata_d;
            op_q    <= mem_op_i;
            off_q   <= mem_addr_i[1:0];
            ld_q    <= mem_rd_i;
            cnt     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + 16'd1;
          // Ack wins over a timeout landing on the same cycle.
          if (dmem_ack_i || timeout) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= ~dmem_ack_i;
            res_q   <= (dmem_ack_i && ld_q) ? ld_fmt : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wd_o         = rst ? '0 : wd_i;
  assign wreg_o       = ~rst & wreg;
  assign wdata_o      = rst ? '0 : wdata;
  assign stallreq_o   = ~rst & stall;
  assign excp_o       = rst ? '0 : excp;
  assign dmem_req_o   = ~rst & req_q;
  assign dmem_we_o    = ~rst & we_q;
  assign dmem_addr_o  = rst ? '0 : addr_q;
  assign dmem_be_o    = rst ? '0 : be_q;
  assign dmem_wdata_o = rst ? '0 : wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: result and bus queues
// checked by monitor processes, stimulus from directed vectors.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic [1:0]  excp_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        ack;
  logic [31:0] rd_word;

  logic resp_ack  = 1'b0;
  logic late_ack  = 1'b0;
  logic issued    = 1'b0;
  int   ack_lat   = -1;
  int   rcnt      = 0;
  int   last_len  = 0;
  int   n_pass    = 0;
  int   n_total   = 0;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [1:0]  excp;
    logic        chk_data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  assign ack = resp_ack | late_ack;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .mem_rd_i     (mem_rd_i),
    .mem_wr_i     (mem_wr_i),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .mem_sdata_i  (mem_sdata_i),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stallreq_o   (stallreq_o),
    .excp_o       (excp_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (ack),
    .dmem_rdata_i (rd_word)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: got event want none", name);
  endtask

  task automatic push_exp(input logic [4:0] wd,
                          input logic wreg,
                          input logic [31:0] wdata,
                          input logic [1:0] excp,
                          input logic chk_data);
    exp_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata;
    e.excp = excp; e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask

  task automatic push_bus(input logic we,
                          input logic [31:0] addr,
                          input logic [3:0] be,
                          input logic [31:0] wdata);
    bus_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  task automatic nop_inputs();
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_op_i = '0;
    mem_addr_i = '0; mem_sdata_i = '0;
  endtask

  // Holds the instruction until the stage stops stalling.
  task automatic issue(input logic rd, input logic wr,
                       input logic [2:0] op,
                       input logic [31:0] addr,
                       input logic [31:0] sdata,
                       input logic [4:0] wd,
                       input logic wreg,
                       input logic [31:0] wdata,
                       input int lat,
                       input logic [31:0] rdata,
                       output int stalls);
    ack_lat  = lat;
    rd_word  = rdata;
    last_len = 0;
    @(posedge clk); #1;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    mem_rd_i = rd; mem_wr_i = wr; mem_op_i = op;
    mem_addr_i = addr; mem_sdata_i = sdata;
    issued = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stallreq_o) break;
      stalls++;
      if (stalls > 40) begin
        fail("stall_bound");
        break;
      end
    end
    @(posedge clk); #1;
    issued = 1'b0;
    nop_inputs();
  endtask

  always @(negedge clk) begin
    if (!rst && issued && !stallreq_o) begin
      if (exp_q.size() == 0) begin
        fail("result_unexpected");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wd_o", 32'(wd_o), 32'(e.wd));
        chk("wreg_o", 32'(wreg_o), 32'(e.wreg));
        chk("excp_o", 32'(excp_o), 32'(e.excp));
        if (e.chk_data) chk("wdata_o", wdata_o, e.wdata);
      end
    end
  end

  // Bus slave: checks the first request cycle, acks after ack_lat.
  always @(negedge clk) begin
    if (rst) begin
      rcnt     = 0;
      resp_ack = 1'b0;
    end else if (dmem_req_o) begin
      if (rcnt == 0) begin
        if (bus_q.size() == 0) begin
          fail("bus_unexpected");
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("dmem_we", 32'(dmem_we_o), 32'(b.we));
          chk("dmem_addr", dmem_addr_o, b.addr);
          chk("dmem_be", 32'(dmem_be_o), 32'(b.be));
          if (b.we) chk("dmem_wdata", dmem_wdata_o, b.wdata);
        end
      end
      rcnt++;
      resp_ack = (ack_lat >= 0) && (rcnt == ack_lat + 1);
    end else begin
      if (rcnt != 0) last_len = rcnt;
      rcnt     = 0;
      resp_ack = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int st;
    rd_word = '0;
    rst = 1'b1;
    wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
    mem_rd_i = 1'b1; mem_wr_i = 1'b0; mem_op_i = 3'b010;
    mem_addr_i = 32'h40; mem_sdata_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wd", 32'(wd_o), 0);
    chk("rst_wreg", 32'(wreg_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_stall", 32'(stallreq_o), 0);
    chk("rst_req", 32'(dmem_req_o), 0);
    chk("rst_excp", 32'(excp_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nop_inputs();

    push_exp(5'd5, 1'b1, 32'h1234, 2'b00, 1'b1);
    issue(0, 0, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1,
          32'h1234, -1, 32'h0, st);
    chk("pt_stall", st, 0);

    push_bus(1'b0, 32'h1000, 4'b0000, 32'h0);
    push_exp(5'd7, 1'b1, 32'hFFFF_FF80, 2'b00, 1'b1);
    issue(1, 0, 3'b000, 32'h1003, 32'h0, 5'd7, 1'b1,
          32'hDEAD, 3, 32'h80FF_0000, st);
    chk("lb_stall", st, 5);
    chk("lb_req_len", last_len, 4);

    push_bus(1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF);
    push_exp(5'd9, 1'b0, 32'h0, 2'b00, 1'b1);
    issue(0, 1, 3'b001, 32'h2002, 32'hAAAA_BEEF, 5'd9,
          1'b1, 32'h77, 0, 32'h0, st);
    chk("sh_stall", st, 2);
    chk("sh_req_len", last_len, 1);

    push_bus(1'b1, 32'h7000, 4'b0010, 32'h7878_7878);
    push_exp(5'd10, 1'b0, 32'h0, 2'b00, 1'b1);
    issue(0, 1, 3'b000, 32'h7001, 32'h1234_5678, 5'd10,
          1'b1, 32'h0, 1, 32'h0, st);
    chk("sb_stall", st, 3);

    push_bus(1'b1, 32'h8000, 4'b1111, 32'hDEAD_BEEF);
    push_exp(5'd11, 1'b0, 32'h0, 2'b00, 1'b1);
    issue(0, 1, 3'b010, 32'h8000, 32'hDEAD_BEEF, 5'd11,
          1'b1, 32'h0, 0, 32'h0, st);

    push_bus(1'b0, 32'h1000, 4'b0000, 32'h0);
    push_exp(5'd12, 1'b1, 32'hFFFF_8001, 2'b00, 1'b1);
    issue(1, 0, 3'b001, 32'h1002, 32'h0, 5'd12, 1'b1,
          32'h0, 1, 32'h8001_7FFF, st);

    push_bus(1'b0, 32'h1000, 4'b0000, 32'h0);
    push_exp(5'd12, 1'b1, 32'h0000_8001, 2'b00, 1'b1);
    issue(1, 0, 3'b101, 32'h1002, 32'h0, 5'd12, 1'b1,
          32'h0, 0, 32'h8001_7FFF, st);

    push_bus(1'b0, 32'h1000, 4'b0000, 32'h0);
    push_exp(5'd1, 1'b1, 32'h1357_9BDF, 2'b00, 1'b1);
    issue(1, 0, 3'b010, 32'h1000, 32'h0, 5'd1, 1'b1,
          32'h0, 2, 32'h1357_9BDF, st);

    push_exp(5'd13, 1'b0, 32'h0, 2'b01, 1'b0);
    issue(1, 0, 3'b010, 32'h3001, 32'h0, 5'd13, 1'b1,
          32'h99, 0, 32'h0, st);
    chk("misal_stall", st, 0);

    push_exp(5'd14, 1'b0, 32'h0, 2'b11, 1'b0);
    issue(1, 0, 3'b011, 32'h3000, 32'h0, 5'd14, 1'b1,
          32'h0, 0, 32'h0, st);
    chk("ill_stall", st, 0);

    push_exp(5'd15, 1'b0, 32'h0, 2'b11, 1'b0);
    issue(0, 1, 3'b100, 32'h3000, 32'h0, 5'd15, 1'b1,
          32'h0, 0, 32'h0, st);

    push_exp(5'd16, 1'b0, 32'h0, 2'b11, 1'b0);
    issue(1, 1, 3'b010, 32'h3001, 32'h0, 5'd16, 1'b1,
          32'h0, 0, 32'h0, st);

    push_exp(5'd17, 1'b0, 32'h0, 2'b01, 1'b0);
    issue(0, 1, 3'b001, 32'h2001, 32'h0, 5'd17, 1'b1,
          32'h0, 0, 32'h0, st);

    push_bus(1'b0, 32'h6000, 4'b0000, 32'h0);
    push_exp(5'd18, 1'b0, 32'h0, 2'b10, 1'b0);
    issue(1, 0, 3'b010, 32'h6000, 32'h0, 5'd18, 1'b1,
          32'h0, -1, 32'h0, st);
    chk("to_stall", st, 5);
    chk("to_req_len", last_len, 4);

    // Reset lands in the second BUSY cycle of an unanswered load.
    push_bus(1'b0, 32'h5000, 4'b0000, 32'h0);
    ack_lat = -1;
    @(posedge clk); #1;
    wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h55;
    mem_rd_i = 1'b1; mem_op_i = 3'b010;
    mem_addr_i = 32'h5000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", 32'(dmem_req_o), 0);
    chk("mid_rst_stall", 32'(stallreq_o), 0);
    chk("mid_rst_addr", dmem_addr_o, 0);
    chk("mid_rst_wd", 32'(wd_o), 0);
    chk("mid_rst_wdata", wdata_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nop_inputs();
    rd_word = 32'hFFFF_FFFF;
    late_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 32'(dmem_req_o), 0);
    chk("post_rst_stall", 32'(stallreq_o), 0);
    @(posedge clk); #1;
    late_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", 32'(dmem_req_o), 0);

    push_bus(1'b0, 32'h4000, 4'b0000, 32'h0);
    push_exp(5'd20, 1'b1, 32'h0000_009A, 2'b00, 1'b1);
    issue(1, 0, 3'b100, 32'h4001, 32'h0, 5'd20, 1'b1,
          32'h0, 1, 32'h0000_9A00, st);
    chk("lbu_stall", st, 3);

    repeat (2) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access pipeline stage of the RV32I core. It sits between the EX/MEM latch and the MEM/WB latch, so its result feeds the register-file write port (write address, write enable, write data).
- It performs loads and stores over a req/ack data-memory bus, stalling the pipeline until the access completes.
- It applies byte/half alignment, sign/zero extension and store byte enables.
- Non-memory instructions pass through unchanged in zero cycles.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for dmem_ack_i before the access is aborted with a bus error (range 1..65535).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- wd_i  input  5  destination register index from EX
- wreg_i  input  1  destination write enable from EX
- wdata_i  input  32  ALU result from EX
- mem_rd_i  input  1  instruction is a load
- mem_wr_i  input  1  instruction is a store
- mem_op_i  input  3  funct3 of the load/store
- mem_addr_i  input  32  effective byte address
- mem_sdata_i  input  32  store data (rs2)
- wd_o  output  5  destination index to MEM/WB
- wreg_o  output  1  destination write enable to MEM/WB
- wdata_o  output  32  write-back data to MEM/WB
- stallreq_o  output  1  hold all upstream stages
- excp_o  output  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal op
- dmem_req_o  output  1  bus request
- dmem_we_o  output  1  1 = write
- dmem_addr_o  output  32  word address {mem_addr_i[31:2],2'b00}
- dmem_be_o  output  4  byte enables, bit n = byte lane n (little-endian)
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_ack_i  input  1  one-cycle completion pulse
- dmem_rdata_i  input  32  read word, valid with ack

Behaviour:
- State machine: IDLE, BUSY, DONE. Registered state, wait counter, result register and exception register.
- Reset: while rst=1, every output is 0 and the state goes to IDLE, including mid-access. The request is dropped with no handshake.
- Access decode:
  - Illegal op: mem_rd_i and mem_wr_i both 1; load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}.
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
- Pass-through (IDLE, mem_rd_i=mem_wr_i=0): wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stallreq_o=0, excp_o=00. Combinational, zero latency.
- Fault (IDLE, illegal or misaligned):
  - No bus access and no stall.
  - wreg_o=0; excp_o=11 or 01 combinationally for that cycle.
  - Illegal takes priority over misaligned.
- IDLE with a valid access:
  - stallreq_o=1 combinationally.
  - Next state BUSY; dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o are registered and asserted from the next cycle.
- BUSY:
  - stallreq_o=1; request signals held stable; counter increments each cycle.
  - On dmem_ack_i: capture the formatted load data (stores capture 0), deassert req next cycle, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: deassert req, set the error flag, go to DONE.
  - An ack that coincides with the timeout cycle counts as success.
- DONE (exactly one cycle):
  - stallreq_o=0 and wd_o=wd_i.
  - Load success: wreg_o=wreg_i, wdata_o=captured value.
  - Store success: wreg_o=0.
  - Timeout: wreg_o=0, excp_o=10.
  - Next state IDLE. The still-present inputs are not re-issued.
- Load formatting, with byte lane b=addr[1:0]:
  - LB: sign-extend lane b.
  - LBU: zero-extend lane b.
  - LH: sign-extend lanes {addr[1],1}:{addr[1],0}.
  - LHU: same lanes, zero-extended.
  - LW: the full word.
- Store encoding:
  - SB: be=4'b0001<<b, wdata = byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011, wdata = half replicated ×2.
  - SW: be=1111, wdata=mem_sdata_i.
- dmem_be_o=0 for loads.
- dmem_ack_i outside BUSY is ignored.

Test Plan:
- Pass-through: ALU op with wd_i=5, wreg_i=1, wdata_i=0x1234 → same-cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stallreq_o=0, dmem_req_o=0.
- LB: addr 0x1003, rdata 0x80FF_0000, ack 3 cycles after req → stallreq high until DONE; DONE cycle wdata_o=0xFFFFFF80, wreg_o=1; req deasserted the cycle after ack.
- SH: addr 0x2002, sdata 0xAAAA_BEEF → dmem_we_o=1, be=1100, addr=0x2000, wdata=0xBEEFBEEF; DONE cycle wreg_o=0.
- Faults:
  - LW at 0x3001 → excp_o=01, wreg_o=0, no req, no stall.
  - mem_op_i=011 load → excp_o=11.
- Timeout: TIMEOUT_CYCLES=4, LW with no ack → req high 4 cycles, then DONE with excp_o=10, wreg_o=0, stall released.
- Reset mid-operation: rst in the 2nd BUSY cycle → next cycle state IDLE, all outputs 0. A late ack is ignored, and a new LBU from 0x4001 (rdata 0x0000_9A00) returns 0x0000009A.
